// File: rtl/wbm_pkg.sv
// Shared types and slave-port region addresses for the Wishbone command initiator.
package wbm_pkg;

    typedef enum logic [1:0] {
        REG_WR   = 2'd0,
        REG_RD   = 2'd1,
        MEM_WR64 = 2'd2,
        MEM_RD64 = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        IDLE,
        BEAT0,
        GAP,
        BEAT1,
        RESP
    } state_e;

    localparam logic [31:0] WBS_MODE_ADDR  = 32'h3000_0000;
    localparam logic [31:0] WBS_DEBUG_ADDR = 32'h3000_0001;
    localparam logic [31:0] WBS_QUERY_ADDR = 32'h3100_0000;
    localparam logic [31:0] WBS_LEAF_ADDR  = 32'h3200_0000;
    localparam logic [31:0] WBS_BEST_ADDR  = 32'h3300_0000;

    function automatic logic op_is_mem(input op_e op);
        return (op == MEM_WR64) || (op == MEM_RD64);
    endfunction

    function automatic logic op_is_write(input op_e op);
        return (op == REG_WR) || (op == MEM_WR64);
    endfunction

endpackage

// File: rtl/wbm_xfer_ctrl.sv
// Wishbone classic initiator: one beat per register access, two beats per 64-bit memory word,
// with a per-beat ack timeout and a valid/ready response.
module wbm_xfer_ctrl
    import wbm_pkg::*;
#(
    parameter int IDX_W          = 10,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_ni,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [31:0]      cmd_base,
    input  logic [IDX_W-1:0] cmd_idx,
    input  logic [63:0]      cmd_wdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [63:0]      rsp_rdata,
    output logic             rsp_err,
    output logic             wbm_cyc_o,
    output logic             wbm_stb_o,
    output logic             wbm_we_o,
    output logic [3:0]       wbm_sel_o,
    output logic [31:0]      wbm_adr_o,
    output logic [31:0]      wbm_dat_o,
    input  logic [31:0]      wbm_dat_i,
    input  logic             wbm_ack_i
);

    localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT_CYCLES);

    state_e           state, next_state;
    op_e              op_q, op_n;
    logic [31:0]      base_q, base_n;
    logic [IDX_W-1:0] idx_q, idx_n;
    logic [63:0]      wdata_q, wdata_n;
    logic [CNT_W-1:0] cnt;
    logic             accept, ack, expired;
    logic             stb_n, cyc_n, beat_n;
    logic [31:0]      idx_ext, offset, adr_n, dat_n;

    assign accept  = cmd_valid && cmd_ready;
    assign ack     = wbm_ack_i && wbm_stb_o;
    assign expired = wbm_stb_o && !wbm_ack_i && (cnt == TMO);

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) state <= IDLE;
        else            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = BEAT0;
            BEAT0: begin
                if (ack)          next_state = op_is_mem(op_q) ? GAP : RESP;
                else if (expired) next_state = RESP;
            end
            GAP:     next_state = BEAT1;
            BEAT1:   if (ack || expired) next_state = RESP;
            RESP:    if (rsp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Bus outputs are precomputed from next_state so every output comes straight from a flop;
    // on acceptance the command fields bypass their registers so the first beat starts at T+1.
    always_comb begin
        op_n    = op_q;
        base_n  = base_q;
        idx_n   = idx_q;
        wdata_n = wdata_q;
        if (accept) begin
            op_n    = op_e'(cmd_op);
            base_n  = cmd_base;
            idx_n   = cmd_idx;
            wdata_n = cmd_wdata;
        end
        stb_n   = (next_state == BEAT0) || (next_state == BEAT1);
        cyc_n   = stb_n || (next_state == GAP);
        beat_n  = (next_state == BEAT1);
        idx_ext = 32'(idx_n);
        offset  = op_is_mem(op_n) ? {idx_ext[30:0], beat_n} : idx_ext;
        adr_n   = stb_n ? (base_n + offset) : 32'h0;
        dat_n   = 32'h0;
        if (stb_n) dat_n = beat_n ? wdata_n[63:32] : wdata_n[31:0];
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            cnt       <= '0;
            op_q      <= REG_WR;
            base_q    <= 32'h0;
            idx_q     <= '0;
            wdata_q   <= 64'h0;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 64'h0;
            rsp_err   <= 1'b0;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_sel_o <= 4'h0;
            wbm_adr_o <= 32'h0;
            wbm_dat_o <= 32'h0;
        end else begin
            op_q      <= op_n;
            base_q    <= base_n;
            idx_q     <= idx_n;
            wdata_q   <= wdata_n;
            cmd_ready <= (next_state == IDLE);
            rsp_valid <= (next_state == RESP);
            wbm_cyc_o <= cyc_n;
            wbm_stb_o <= stb_n;
            wbm_we_o  <= stb_n && op_is_write(op_n);
            wbm_sel_o <= stb_n ? 4'hF : 4'h0;
            wbm_adr_o <= adr_n;
            wbm_dat_o <= dat_n;
            // Counter restarts on every beat entry; it only survives while a beat waits for ack.
            if (stb_n && (next_state == state)) cnt <= cnt + 1'b1;
            else                                cnt <= '0;
            if (accept) begin
                rsp_rdata <= 64'h0;
                rsp_err   <= 1'b0;
            end else begin
                if (ack && !op_is_write(op_q)) begin
                    if (state == BEAT1) rsp_rdata[63:32] <= wbm_dat_i;
                    else                rsp_rdata[31:0]  <= wbm_dat_i;
                end
                if (expired) rsp_err <= 1'b1;
            end
        end
    end

endmodule
